// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the serial pattern generator.
// Holds the FSM state encoding, default widths and a bit-count helper.
// The helper is pure arithmetic and is intended for benches and checkers.
package seq_gen_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_LEN_W  = 4;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Number of valid cycles a transmission produces: len * (repeat + 1).
    function automatic int unsigned bit_count(input int unsigned len, input int unsigned rep);
        return len * (rep + 1);
    endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable pattern register with a variable-length MSB tap.
// Latency: the tap reflects the register's next state, so the caller can register it in the same edge.
// No backpressure: load, reload and shift are applied unconditionally when asserted.
module seq_shift_reg
    import seq_gen_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              reload_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic [LEN_W-1:0]  tap_sel_i,
    output logic              nxt_bit_o
);

    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] shift_d;

    // Next contents: a fresh load, a reload of the captured word, or a one-bit advance.
    always_comb begin
        word_d  = word_q;
        shift_d = shift_q;
        if (load_i) begin
            word_d  = word_i;
            shift_d = word_i;
        end else if (reload_i) begin
            shift_d = word_q;
        end else if (shift_i) begin
            shift_d = shift_q << 1;
        end
    end

    // The bit at position len-1 of the next contents is the next bit to transmit.
    assign nxt_bit_o = |(shift_d & (WORD_W'(1) << tap_sel_i));

    // Captured word and working shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            shift_q <= '0;
        end else begin
            word_q  <= word_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends word[len-1:0] MSB-first, repeat+1 times, back-to-back.
// Latency: first bit appears the cycle after start is sampled; done pulses the cycle after the last bit.
// No backpressure: start is only honoured in IDLE; abort cancels SEND on the next cycle.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int   WORD_W   = DEF_WORD_W,
    parameter int   LEN_W    = DEF_LEN_W,
    parameter int   CNT_W    = DEF_CNT_W,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [CNT_W-1:0]  repeat_in,
    input  logic              abort,
    output logic              seq_out,
    output logic              seq_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WORD_W);
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  rep_q, rep_d;
    logic              seq_out_q, seq_out_d;
    logic              seq_valid_q, seq_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              load;
    logic              reload;
    logic              shift;
    logic              len_ok;
    logic [LEN_W-1:0]  tap_sel;
    logic              nxt_bit;

    assign len_ok  = (len_in != '0) && (len_in <= MAX_LEN);
    // While idle the tap must follow the incoming length so the first bit is ready at the load edge.
    assign tap_sel = (state_q == ST_IDLE) ? (len_in - ONE_LEN) : (len_q - ONE_LEN);

    seq_shift_reg #(
        .WORD_W (WORD_W),
        .LEN_W  (LEN_W)
    ) u_shift (
        .clk       (clk),
        .rst_n     (reset),
        .load_i    (load),
        .reload_i  (reload),
        .shift_i   (shift),
        .word_i    (word_in),
        .tap_sel_i (tap_sel),
        .nxt_bit_o (nxt_bit)
    );

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        bit_cnt_d   = bit_cnt_q;
        rep_d       = rep_q;
        seq_out_d   = IDLE_LVL;
        seq_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        load        = 1'b0;
        reload      = 1'b0;
        shift       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (len_ok) begin
                        load        = 1'b1;
                        len_d       = len_in;
                        bit_cnt_d   = len_in - ONE_LEN;
                        rep_d       = repeat_in;
                        seq_out_d   = nxt_bit;
                        seq_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = ST_SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (abort) begin
                    bit_cnt_d = '0;
                    rep_d     = '0;
                    state_d   = ST_IDLE;
                end else if (bit_cnt_q != '0) begin
                    shift       = 1'b1;
                    bit_cnt_d   = bit_cnt_q - ONE_LEN;
                    seq_out_d   = nxt_bit;
                    seq_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end else if (rep_q != '0) begin
                    // Reload on the last bit so the next repetition starts without a gap.
                    reload      = 1'b1;
                    rep_d       = rep_q - CNT_W'(1);
                    bit_cnt_d   = len_q - ONE_LEN;
                    seq_out_d   = nxt_bit;
                    seq_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            bit_cnt_q   <= '0;
            rep_q       <= '0;
            seq_out_q   <= IDLE_LVL;
            seq_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            bit_cnt_q   <= bit_cnt_d;
            rep_q       <= rep_d;
            seq_out_q   <= seq_out_d;
            seq_valid_q <= seq_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign seq_out   = seq_out_q;
    assign seq_valid = seq_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: scoreboard of expected bits, one task per scenario.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Every collection window is a fixed number of cycles, so the run always ends.
module tb_seq_pattern_gen;
    import seq_gen_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] word_in;
    logic [3:0] len_in;
    logic [3:0] repeat_in;
    logic       abort;
    logic       seq_out;
    logic       seq_valid;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic exp_q[$];
    logic obs_q[$];
    int   done_idx, first_v, last_v, n_done, n_err, busy_hi, bad_idle;
    logic busy_at_done;
    bit   gap;

    always #5 clk = ~clk;

    seq_pattern_gen dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .word_in   (word_in),
        .len_in    (len_in),
        .repeat_in (repeat_in),
        .abort     (abort),
        .seq_out   (seq_out),
        .seq_valid (seq_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Scoreboard: expected bit stream for one transmission.
    task automatic push_expected(input logic [7:0] w, input int len, input int rep);
        for (int r = 0; r <= rep; r++)
            for (int b = len - 1; b >= 0; b--)
                exp_q.push_back(w[b]);
    endtask

    // Present one start pulse; returns 1 unit into the cycle after the sampling edge.
    task automatic do_start(input logic [7:0] w, input logic [3:0] len,
                            input logic [3:0] rep, input logic ab);
        word_in   = w;
        len_in    = len;
        repeat_in = rep;
        abort     = ab;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Record n cycles of output activity (no judgement here).
    task automatic collect(input int n);
        obs_q.delete();
        done_idx = -1; first_v = -1; last_v = -1;
        n_done = 0; n_err = 0; busy_hi = 0; bad_idle = 0;
        busy_at_done = 1'bx; gap = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (seq_valid === 1'b1) begin
                obs_q.push_back(seq_out);
                if (first_v < 0) first_v = i;
                else if (last_v != i - 1) gap = 1'b1;
                last_v = i;
            end else if (seq_out !== 1'b0) begin
                bad_idle++;
            end
            if (done === 1'b1) begin
                n_done++;
                if (done_idx < 0) begin
                    done_idx     = i;
                    busy_at_done = busy;
                end
            end
            if (err === 1'b1) n_err++;
            if (busy === 1'b1) busy_hi++;
            @(posedge clk); #1;
        end
    endtask

    // Overlapping 3-bit pattern count, as a Mealy detector on the stream would report.
    function automatic int count_pat(input logic [2:0] p);
        int c = 0;
        for (int i = 2; i < obs_q.size(); i++)
            if ({obs_q[i-2], obs_q[i-1], obs_q[i]} === p) c++;
        return c;
    endfunction

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        word_in = '0; len_in = '0; repeat_in = '0;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({seq_out, seq_valid, busy, done, err} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs got %b want 00000", {seq_out, seq_valid, busy, done, err});
        end
        reset = 1'b1;
        collect(3);
        checks++;
        if (busy_hi !== 0 || n_done !== 0 || n_err !== 0 || obs_q.size() !== 0 || bad_idle !== 0) begin
            errors++; $display("FAIL post_reset_idle got busy=%0d done=%0d err=%0d valid=%0d want all 0",
                               busy_hi, n_done, n_err, obs_q.size());
        end
    endtask

    task automatic test_basic();
        logic e, o;
        push_expected(8'b0000_0001, 3, 2);
        do_start(8'b0000_0001, 4'd3, 4'd2, 1'b0);
        collect(12);
        checks++;
        if (obs_q.size() !== int'(bit_count(3, 2))) begin
            errors++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), bit_count(3, 2));
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = (i < obs_q.size()) ? obs_q[i] : 1'bx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL basic_bit%0d got %b want %b", i, o, e); end
        end
        checks++;
        if (first_v !== 0 || gap !== 1'b0) begin
            errors++; $display("FAIL basic_latency first=%0d gap=%0b want 0,0", first_v, gap);
        end
        checks++;
        if (done_idx !== 9 || n_done !== 1 || busy_at_done !== 1'b0) begin
            errors++; $display("FAIL basic_done idx=%0d n=%0d busy=%b want 9,1,0", done_idx, n_done, busy_at_done);
        end
        checks++;
        if (busy_hi !== 9 || bad_idle !== 0) begin
            errors++; $display("FAIL basic_busy got %0d idle_bad=%0d want 9,0", busy_hi, bad_idle);
        end
        checks++;
        if (count_pat(3'b001) !== 3) begin
            errors++; $display("FAIL basic_001_hits got %0d want 3", count_pat(3'b001));
        end
    endtask

    task automatic test_back_to_back();
        logic e, o;
        push_expected(8'b1101_1001, 8, 0);
        do_start(8'b1101_1001, 4'd8, 4'd0, 1'b0);
        collect(9);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = (i < obs_q.size()) ? obs_q[i] : 1'bx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL full_bit%0d got %b want %b", i, o, e); end
        end
        checks++;
        if (done_idx !== 8 || obs_q.size() !== 8) begin
            errors++; $display("FAIL full_done idx=%0d bits=%0d want 8,8", done_idx, obs_q.size());
        end
        checks++;
        if (count_pat(3'b110) !== 2) begin
            errors++; $display("FAIL full_110_hits got %0d want 2", count_pat(3'b110));
        end
        // Now in the first IDLE cycle after FIN: a start here must be taken.
        push_expected(8'b0000_0110, 4, 0);
        do_start(8'b0000_0110, 4'd4, 4'd0, 1'b0);
        collect(6);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = (i < obs_q.size()) ? obs_q[i] : 1'bx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_bit%0d got %b want %b", i, o, e); end
        end
        checks++;
        if (first_v !== 0 || done_idx !== 4) begin
            errors++; $display("FAIL b2b_timing first=%0d done=%0d want 0,4", first_v, done_idx);
        end
    endtask

    task automatic test_illegal();
        do_start(8'hFF, 4'd0, 4'd0, 1'b0);
        collect(3);
        checks++;
        if (n_err !== 1 || busy_hi !== 0 || obs_q.size() !== 0) begin
            errors++; $display("FAIL len0_err err=%0d busy=%0d bits=%0d want 1,0,0", n_err, busy_hi, obs_q.size());
        end
        do_start(8'hFF, 4'd9, 4'd0, 1'b0);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL len9_err_pulse got %b want 1", err); end
        collect(3);
        checks++;
        if (n_err !== 1 || busy_hi !== 0 || obs_q.size() !== 0) begin
            errors++; $display("FAIL len9_err err=%0d busy=%0d bits=%0d want 1,0,0", n_err, busy_hi, obs_q.size());
        end
    endtask

    task automatic test_len1_rep15();
        logic e, o;
        push_expected(8'h01, 1, 15);
        do_start(8'h01, 4'd1, 4'd15, 1'b0);
        collect(19);
        checks++;
        if (obs_q.size() !== int'(bit_count(1, 15)) || gap !== 1'b0) begin
            errors++; $display("FAIL len1_count got %0d gap=%0b want %0d,0", obs_q.size(), gap, bit_count(1, 15));
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = (i < obs_q.size()) ? obs_q[i] : 1'bx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL len1_bit%0d got %b want %b", i, o, e); end
        end
        checks++;
        if (done_idx !== 16 || n_done !== 1) begin
            errors++; $display("FAIL len1_done idx=%0d n=%0d want 16,1", done_idx, n_done);
        end
    endtask

    task automatic test_abort();
        logic e, o;
        push_expected(8'hB4, 8, 0);
        do_start(8'hB4, 4'd8, 4'd0, 1'b0);
        fork
            collect(8);
            begin
                repeat (2) @(posedge clk); #1;
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
            end
        join
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            o = (i < obs_q.size()) ? obs_q[i] : 1'bx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL abort_bit%0d got %b want %b", i, o, e); end
        end
        exp_q.delete();
        checks++;
        if (obs_q.size() !== 3 || busy_hi !== 3 || n_done !== 0 || bad_idle !== 0) begin
            errors++; $display("FAIL abort_stop bits=%0d busy=%0d done=%0d idle_bad=%0d want 3,3,0,0",
                               obs_q.size(), busy_hi, n_done, bad_idle);
        end
    endtask

    task automatic test_start_abort_idle();
        do_start(8'hA5, 4'd8, 4'd1, 1'b1);
        collect(4);
        checks++;
        if (obs_q.size() !== 0 || busy_hi !== 0 || n_err !== 0) begin
            errors++; $display("FAIL start_abort bits=%0d busy=%0d err=%0d want 0,0,0", obs_q.size(), busy_hi, n_err);
        end
        do_start(8'hA5, 4'd0, 4'd0, 1'b1);
        collect(3);
        checks++;
        if (n_err !== 0 || busy_hi !== 0) begin
            errors++; $display("FAIL start_abort_len0 err=%0d busy=%0d want 0,0", n_err, busy_hi);
        end
    endtask

    task automatic test_start_during_send();
        logic e, o;
        push_expected(8'h96, 6, 1);
        do_start(8'h96, 4'd6, 4'd1, 1'b0);
        fork
            collect(15);
            begin
                repeat (3) @(posedge clk); #1;
                word_in = 8'hFF; len_in = 4'd2; repeat_in = 4'd0; start = 1'b1;
                repeat (2) @(posedge clk); #1;
                start = 1'b0;
            end
        join
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = (i < obs_q.size()) ? obs_q[i] : 1'bx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL busy_start_bit%0d got %b want %b", i, o, e); end
        end
        checks++;
        if (obs_q.size() !== 12 || done_idx !== 12 || n_done !== 1 || n_err !== 0) begin
            errors++; $display("FAIL busy_start_shape bits=%0d done=%0d n=%0d err=%0d want 12,12,1,0",
                               obs_q.size(), done_idx, n_done, n_err);
        end
    endtask

    task automatic test_reset_midstream();
        do_start(8'h0B, 4'd4, 4'd3, 1'b0);
        repeat (4) @(posedge clk); #1;
        checks++;
        if (seq_valid !== 1'b1 || seq_out !== 1'b1) begin
            errors++; $display("FAIL mid_5th_bit valid=%b out=%b want 1,1", seq_valid, seq_out);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({seq_out, seq_valid, busy, done, err} !== 5'b0) begin
            errors++; $display("FAIL mid_reset_async got %b want 00000", {seq_out, seq_valid, busy, done, err});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        collect(6);
        checks++;
        if (n_done !== 0 || busy_hi !== 0 || obs_q.size() !== 0) begin
            errors++; $display("FAIL mid_reset_after done=%0d busy=%0d bits=%0d want 0,0,0", n_done, busy_hi, obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_len1_rep15();
        test_abort();
        test_start_abort_idle();
        test_start_during_send();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial pattern transmitter: the stimulus end of the serial bit-stream interface that the Mealy sequence detectors (mealy_fsm, mealy_001, mealy_110) consume.
- Loads a word of programmable length and shifts it out MSB-first, one bit per clock, optionally repeated back-to-back.
- Its seq_out drives a detector's in_seq input directly. This replaces hand-timed stimulus in benches and feeds detectors in-system.

Parameters:
- WORD_W, 8, maximum pattern length in bits.
- LEN_W, 4, width of len_in; must satisfy 2**LEN_W > WORD_W.
- CNT_W, 4, width of repeat_in.
- IDLE_LVL, 1'b0, value driven on seq_out when not transmitting.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a transmission; sampled in IDLE only.
- word_in  in  WORD_W  pattern; bits [len_in-1:0] are used, bit len_in-1 is sent first.
- len_in  in  LEN_W  pattern length; legal range is 1..WORD_W.
- repeat_in  in  CNT_W  extra repetitions; the pattern is sent repeat_in+1 times.
- abort  in  1  synchronous cancel of a transmission in progress.
- seq_out  out  1  serial bit stream.
- seq_valid  out  1  high while seq_out carries a pattern bit.
- busy  out  1  high from the cycle after an accepted start until transmission ends.
- done  out  1  one-cycle pulse after the last bit of the last repetition.
- err  out  1  one-cycle pulse when start is rejected for an illegal len_in.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, seq_out=IDLE_LVL, seq_valid=0, busy=0, done=0, err=0, all counters 0. Reset asserted mid-transmission takes effect immediately; no done pulse.
- All outputs are registered.
- States: IDLE, SEND, FIN.
- IDLE:
  - start=1, abort=0, 1<=len_in<=WORD_W: capture word_in, len_in, repeat_in; go to SEND.
  - start=1 with len_in=0 or len_in>WORD_W: err=1 for the next cycle, stay in IDLE.
  - start=1 and abort=1 together: abort wins, start is ignored, no err.
- Latency: start sampled at edge k; first bit (word[len-1]) appears on seq_out with seq_valid=1 and busy=1 in the cycle following edge k.
- SEND:
  - One bit per cycle, MSB of the active length first: word[len-1], word[len-2], ..., word[0].
  - Bit counter counts down len-1..0.
  - At bit 0 with repetitions remaining: reload from the captured word, decrement the repeat counter, and send word[len-1] on the very next cycle. No gap and no valid drop between repetitions.
  - At bit 0 with no repetitions remaining: go to FIN.
- FIN (one cycle): done=1, seq_valid=0, busy=0, seq_out=IDLE_LVL; then IDLE.
  - start is not accepted in FIN. The earliest new start is sampled at the edge leaving IDLE's first cycle.
- start while busy: ignored, no err. Captured values are unaffected by input changes during transmission.
- abort=1 in SEND: next cycle is IDLE with seq_valid=0, busy=0, seq_out=IDLE_LVL, done=0.
- Total valid cycles per transmission = len*(repeat_in+1). Counters must not wrap at repeat_in=2**CNT_W-1 or len=WORD_W.
- len_in=1 is legal: word[0] is sent repeat_in+1 times.

Decomposition:
- Package seq_gen_pkg:
  - State encoding (IDLE/SEND/FIN).
  - Default widths.
  - Function computing the bit count as len*(repeat+1), for benches.
- Sub-module seq_shift_reg:
  - WORD_W-bit loadable register with a variable-length MSB tap, selected by captured len-1.
  - Load/shift enable inputs.
  - The FSM and counters live in the top.

Test Plan:
- Reset mid-stream: start word=8'h0B, len=4, repeat=3; drive reset=0 on the 5th valid cycle -> all outputs go to reset values immediately; no done.
- Basic: word=8'b0000_0001, len=3, repeat=2, start at edge k -> seq_out=0,0,1,0,0,1,0,0,1 with seq_valid=1 for cycles k+1..k+9; done=1 at k+10; busy low at k+10. mealy_001 output must pulse three times.
- Back-to-back/full length: word=8'b1101_1001, len=8, repeat=0 -> 1,1,0,1,1,0,0,1; done after 8 valid cycles. mealy_110 must assert twice. Then start again in the first IDLE cycle -> accepted.
- Illegal/edge length: len=0 and len=9 -> err pulses, busy stays 0. len=1, word=1, repeat=15 -> 16 consecutive 1s with no wrap, then done.
- Abort and collisions: abort on the 3rd bit -> IDLE next cycle, no done. start+abort in IDLE -> nothing starts. start during SEND -> ignored; the stream is unchanged.
